// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Measures the period of a divided clock (sampled as data in the i_clk domain),
// checks each period against the expected division ratio, declares lock after
// a run of good periods and flags stopped or wrong-ratio clocks.
module clk_div_monitor #(
  parameter int DIV_RATIO   = 4,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT_CYC = 4 * DIV_RATIO,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_div_clk,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_timeout
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [GOOD_W-1:0] LOCK_VAL    = GOOD_W'(LOCK_CNT);

  logic              s1, s2, s3;
  logic              rise;
  logic [1:0]        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [GOOD_W-1:0] good, good_next, good_inc;
  logic [CNT_W-1:0]  period_next;
  logic              vld_next, locked_next, timeout_next, err_next, err_set;
  logic              in_tol;
  int                cnt_i;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_div_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Tolerance window and saturating good-period increment.
  always_comb begin
    cnt_i    = int'(cnt);
    in_tol   = (cnt_i >= DIV_RATIO - TOL) && (cnt_i <= DIV_RATIO + TOL);
    good_inc = (good == LOCK_VAL) ? good : good + GOOD_W'(1);
  end

  // Next-state logic: period measurement, lock tracking, timeout and enable.
  always_comb begin
    state_next   = state;
    // cnt restarts on each rising edge; saturation only matters while waiting
    // for the first edge, since the timeout fires long before wrap otherwise.
    cnt_next     = rise ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1));
    good_next    = good;
    period_next  = o_period;
    vld_next     = 1'b0;
    locked_next  = o_locked;
    timeout_next = 1'b0;
    err_set      = 1'b0;

    if (!i_en) begin
      state_next  = ST_IDLE;
      cnt_next    = '0;
      good_next   = '0;
      locked_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_ACQUIRE;
          cnt_next   = '0;
        end
        ST_ACQUIRE: begin
          if (rise) state_next = ST_MEASURE;
        end
        ST_MEASURE, ST_LOCKED: begin
          if (rise) begin
            // A rising edge wins over a simultaneous timeout.
            period_next = cnt;
            vld_next    = 1'b1;
            if (in_tol) begin
              good_next = good_inc;
              if (state == ST_MEASURE && good_inc == LOCK_VAL) begin
                state_next  = ST_LOCKED;
                locked_next = 1'b1;
              end
            end else begin
              good_next = '0;
              if (state == ST_LOCKED) begin
                err_set     = 1'b1;
                locked_next = 1'b0;
                state_next  = ST_MEASURE;
              end
            end
          end else if (cnt == TIMEOUT_VAL) begin
            timeout_next = 1'b1;
            err_set      = 1'b1;
            locked_next  = 1'b0;
            good_next    = '0;
            state_next   = ST_ACQUIRE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Setting the error takes priority over clearing it.
    err_next = err_set ? 1'b1 : (i_err_clr ? 1'b0 : o_err);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      good         <= '0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      good         <= good_next;
      o_period     <= period_next;
      o_period_vld <= vld_next;
      o_locked     <= locked_next;
      o_err        <= err_next;
      o_timeout    <= timeout_next;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
// Randomized bench with a rise-time based reference model feeding a scoreboard
// queue; a separate monitor checks every DUT pulse and the steady outputs.
module tb_clk_div_monitor;

  localparam int DIV  = 4;
  localparam int TOL  = 0;
  localparam int LOCK = 4;
  localparam int TMO  = 16;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst, en, div_clk, err_clr;
  logic [W-1:0] period;
  logic         period_vld, locked, err, timeout;

  typedef struct {
    int period;
    bit locked;
    bit err;
    bit timeout;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model state
  int  n = 0;
  bit  h1, h2, h3;
  bit  active, have_edge, m_locked, m_err;
  int  last_rise, streak, last_period;
  int  to_seen = 0;
  bit  mon_on = 1'b0;

  clk_div_monitor #(
    .DIV_RATIO(DIV), .TOL(TOL), .LOCK_CNT(LOCK), .TIMEOUT_CYC(TMO), .CNT_W(W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_div_clk(div_clk), .i_err_clr(err_clr),
    .o_period(period), .o_period_vld(period_vld), .o_locked(locked),
    .o_err(err), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h1 = 0; h2 = 0; h3 = 0;
    active = 0; have_edge = 0;
    m_locked = 0; m_err = 0;
    streak = 0; last_period = 0; last_rise = 0;
    q.delete();
  endtask

  // One i_clk cycle: the model predicts the result of the next posedge, then
  // the inputs for that edge are driven. A level driven now is seen as a rise
  // two cycles later, so rise = (value two steps ago) & ~(value three steps ago).
  task automatic step(input bit v, input bit e, input bit c, input bit c_on_to = 1'b0);
    bit  rise, set, to, rep, c_eff;
    int  el;
    ev_t ev;
    @(negedge clk);
    rise = h2 & ~h3;
    set = 0; to = 0; rep = 0;
    if (!e) begin
      active = 0; have_edge = 0; m_locked = 0; streak = 0;
    end else if (!active) begin
      active = 1; have_edge = 0;
    end else if (!have_edge) begin
      if (rise) begin
        have_edge = 1; last_rise = n;
      end
    end else begin
      el = n - last_rise;
      if (rise) begin
        rep = 1;
        last_period = el;
        last_rise = n;
        if ((el - DIV <= TOL) && (DIV - el <= TOL)) begin
          if (streak < LOCK) streak++;
          if (streak >= LOCK) m_locked = 1;
        end else begin
          streak = 0;
          if (m_locked) begin
            set = 1; m_locked = 0;
          end
        end
      end else if (el == TMO) begin
        rep = 1; to = 1; set = 1;
        m_locked = 0; streak = 0; have_edge = 0;
      end
    end
    c_eff = c | (c_on_to & to);
    m_err = set ? 1'b1 : (c_eff ? 1'b0 : m_err);
    if (rep) begin
      ev.period = last_period; ev.locked = m_locked; ev.err = m_err; ev.timeout = to;
      q.push_back(ev);
    end
    div_clk = v; en = e; err_clr = c_eff;
    h3 = h2; h2 = h1; h1 = v;
    n++;
  endtask

  task automatic run_period(input int hi, input int lo, input bit e = 1'b1,
                            input bit rand_clr = 1'b0);
    for (int i = 0; i < hi + lo; i++)
      step(i < hi, e, rand_clr && ($urandom_range(0, 19) == 0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mon_on = 1'b0;
    #1;
    chk("rst_period", period, 0);
    chk("rst_vld", period_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    model_reset();
    div_clk = 1'b0; en = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
  endtask

  // Monitor: pops an expected event whenever one is due or the DUT pulses.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on && !rst) begin
        if (timeout) to_seen++;
        if (q.size() > 0 || period_vld || timeout) begin
          if (q.size() == 0) begin
            chk("unexpected_pulse", int'(period_vld) + 2 * int'(timeout), 0);
          end else begin
            ev = q.pop_front();
            chk("ev_vld", period_vld, !ev.timeout);
            chk("ev_timeout", timeout, ev.timeout);
            chk("ev_period", period, ev.period);
            chk("ev_locked", locked, ev.locked);
            chk("ev_err", err, ev.err);
            $display("event t=%0t period=%0d vld=%0b timeout=%0b locked=%0b err=%0b",
                     $time, period, period_vld, timeout, locked, err);
          end
        end
        chk("locked", locked, m_locked);
        chk("err", err, m_err);
        chk("period_hold", period, last_period);
      end
    end
  end

  initial begin
    int to_before;
    rst = 1'b1; en = 1'b0; div_clk = 1'b0; err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Lock acquisition at the nominal ratio
    repeat ($urandom_range(0, 3)) step(0, 1, 0);
    repeat (6) run_period(2, 2);
    chk("acq_locked", locked, 1);
    chk("acq_err", err, 0);
    chk("acq_period", period, 4);

    // One stretched period while locked, then relock
    run_period(2, 3);
    repeat (6) run_period(2, 2);
    chk("ratio_relocked", locked, 1);
    chk("ratio_err_sticky", err, 1);

    // Stopped clock; error clear collides with the timeout
    to_before = to_seen;
    repeat (24) step(0, 1, 0, 1'b1);
    chk("stop_timeout_once", to_seen - to_before, 1);
    chk("stop_err", err, 1);
    chk("stop_locked", locked, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    chk("clr_err", err, 0);
    repeat (6) run_period(2, 2);
    chk("restart_locked", locked, 1);

    // Reset in the middle of a period while locked
    step(1, 1, 0);
    @(posedge clk);
    #3;
    apply_reset();
    repeat ($urandom_range(0, 3)) step(0, 1, 0);
    repeat (6) run_period(2, 2);
    chk("post_rst_locked", locked, 1);

    // Disable while locked
    repeat (3) run_period(2, 2, 1'b0);
    chk("dis_locked", locked, 0);
    chk("dis_period", period, 4);

    // Randomized traffic: mostly nominal periods, some wrong, some stalls
    for (int k = 0; k < 300; k++) begin
      int hi, lo;
      hi = $urandom_range(1, 3);
      if ($urandom_range(0, 9) < 7) lo = 4 - hi;
      else lo = $urandom_range(1, 20);
      run_period(hi, lo, $urandom_range(0, 29) != 0, 1'b1);
    end
    step(0, 1, 0);
    step(0, 1, 0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Frequency and lock monitor for a divided clock produced by the clock divider stage. It samples the divided clock as a data signal in the source clock domain, measures the period between rising edges in source-clock cycles, and compares each period against the expected division ratio. It declares lock after a run of consecutive correct periods and flags stopped or wrong-ratio clocks to the system controller.

## Interface
Parameters:
- DIV_RATIO, 4: expected divided-clock period, in i_clk cycles; legal range is 2 and above.
- TOL, 0: allowed absolute deviation of a measured period from DIV_RATIO, in cycles.
- LOCK_CNT, 4: number of consecutive in-tolerance periods required to assert lock; legal range is 1 and above.
- TIMEOUT_CYC, 4*DIV_RATIO: number of cycles with no rising edge before a timeout is declared.
- CNT_W, 8: width of the period counter and of o_period; 2^CNT_W-1 must be at least TIMEOUT_CYC.

Ports:
- i_clk, in, 1: source clock; the only clock of the block.
- i_rst, in, 1: reset. Asynchronous, active-high; clears all state.
- i_en, in, 1: monitor enable. Low forces IDLE.
- i_div_clk, in, 1: divided clock under test, treated as data.
- i_err_clr, in, 1: single-cycle clear of o_err.
- o_period, out, CNT_W: last measured period, in i_clk cycles.
- o_period_vld, out, 1: one-cycle pulse when o_period is updated.
- o_locked, out, 1: divided clock is running at the expected ratio.
- o_err, out, 1: sticky error flag.
- o_timeout, out, 1: one-cycle pulse on timeout.

## Operation
- **Input capture.** i_div_clk passes through a 2-flop synchronizer (s1, s2) and then a history flop s3. A rising edge is detected (`rise`) when s2 is 1 and s3 is 0.
- **Counter.** `cnt` loads 1 on `rise` and otherwise increments each cycle. It never wraps, because the timeout condition fires first.
- **States:** IDLE, ACQUIRE, MEASURE, LOCKED.
  - IDLE: i_en=0. `cnt` is 0 and the good-period count `good` is 0. When i_en=1, go to ACQUIRE.
  - ACQUIRE: wait for the first `rise`. Load `cnt` and go to MEASURE. No period is reported.
  - MEASURE, on `rise`:
    - Set o_period to `cnt` and pulse o_period_vld.
    - An in-tolerance period (|cnt − DIV_RATIO| ≤ TOL) increments `good`.
    - An out-of-tolerance period clears `good` to 0. It does not set o_err.
    - When `good` reaches LOCK_CNT, go to LOCKED and set o_locked.
  - LOCKED, on `rise`: report the period the same way as MEASURE. An out-of-tolerance period sets o_err, clears o_locked and `good`, and goes to MEASURE.
- **Timeout.** In MEASURE or LOCKED, if `cnt` equals TIMEOUT_CYC with no `rise` in the same cycle:
  - pulse o_timeout, set o_err, clear o_locked and `good`;
  - go to ACQUIRE.
  - If `rise` and `cnt`=TIMEOUT_CYC occur in the same cycle, `rise` wins and the period is evaluated normally.
- **Enable.** i_en=0 in any state returns the block to IDLE on the next edge:
  - o_locked and `good` are cleared;
  - no vld or timeout pulse is generated;
  - o_err and o_period hold their values.
- **Error clear.** i_err_clr clears o_err. If an error-set event occurs in the same cycle, the set wins.
- **Reset.** Every output is reset to 0. Reset may assert mid-period; all state clears immediately, with no pulse generated.

## Timing
- A rising edge on i_div_clk reaches `rise` 2–3 i_clk edges later, depending on synchronizer sampling.
- o_period and o_period_vld are registered. They update on the edge after `rise` is seen.
- A steady input of period N yields o_period=N exactly. Jitter of ±1 is possible only when the input is asynchronous to i_clk.
- Lock time from enable: first edge, plus LOCK_CNT full periods, plus one cycle.
- o_locked deassertion, the o_err set, and the o_timeout pulse all occur in the same cycle as the o_period_vld that triggers them. For a timeout, they occur in the cycle after `cnt` reaches TIMEOUT_CYC.

## Test plan
- **Lock acquisition.** Defaults; i_div_clk toggles every 2 cycles, synchronous to i_clk; i_en=1 after reset → o_period_vld each 4 cycles with o_period=4. o_locked rises with the 4th vld. o_err stays 0.
- **Wrong ratio while locked.** After lock, stretch one period to 5 with TOL=0 → that vld carries o_period=5. o_err=1 and o_locked=0 in the same cycle. Lock re-asserts after 4 more periods of 4; o_err remains 1.
- **Stopped clock.** After lock, hold i_div_clk at 0 → o_timeout pulses once when 16 cycles elapse after the last `rise`. o_err=1, o_locked=0, state ACQUIRE. Restarting toggling relocks after the first edge plus 4 periods.
- **Clear/set collision.** Assert i_err_clr in the same cycle as a timeout → o_err remains 1. Asserting i_err_clr alone afterwards gives o_err=0 on the next cycle.
- **Reset mid-operation.** Assert i_rst mid-period while locked → all outputs are 0 immediately, with no vld or timeout pulse. After release, the block behaves as in the lock-acquisition scenario.
- **Disable.** Drop i_en while locked → o_locked=0 next cycle. No further vld pulses; o_period keeps its last value of 4.
